// File: rtl/matrix_writer.sv
// matrix_writer: stores one matrix into a BRAM slot as three header words
// (shape, name bytes 0-3, name bytes 4-7) followed by the row-major elements.
// Oversized matrices are rejected without touching the BRAM.
module matrix_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int BLOCK_SIZE = 256,
  parameter int META_WORDS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_request,
  output logic                  write_ready,
  input  logic [2:0]            matrix_id,
  input  logic [7:0]            actual_rows,
  input  logic [7:0]            actual_cols,
  input  logic [7:0]            matrix_name [0:7],
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  writer_ready,
  output logic                  write_done,
  output logic                  write_err,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata
);

  typedef enum logic [2:0] {
    IDLE,
    META0,
    META1,
    META2,
    STREAM,
    DONE,
    ERR
  } state_t;

  localparam logic [15:0] CAPACITY = 16'(BLOCK_SIZE - META_WORDS);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [7:0]            r_rows;
  logic [7:0]            r_cols;
  logic [7:0]            r_name [0:7];
  logic [15:0]           r_elem;
  logic [15:0]           r_idx;

  logic [ADDR_WIDTH-1:0] w_base;
  logic [15:0]           w_elem;

  assign w_base = ADDR_WIDTH'(32'(matrix_id) * 32'(BLOCK_SIZE));
  assign w_elem = 16'(actual_rows) * 16'(actual_cols);

  // Sequencer: captures the request, walks header words, then counts element beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_rows  <= '0;
      r_cols  <= '0;
      r_elem  <= '0;
      r_idx   <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        r_name[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (write_request) begin
            r_base <= w_base;
            r_rows <= actual_rows;
            r_cols <= actual_cols;
            r_elem <= w_elem;
            r_idx  <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
              r_name[i] <= matrix_name[i];
            end
            r_state <= (w_elem > CAPACITY) ? ERR : META0;
          end
        end
        META0: r_state <= META1;
        META1: r_state <= META2;
        META2: r_state <= (r_elem != 16'd0) ? STREAM : DONE;
        STREAM: begin
          if (data_valid) begin
            r_idx <= r_idx + 16'd1;
            if (r_idx + 16'd1 == r_elem) begin
              r_state <= DONE;
            end
          end
        end
        DONE:    r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output decode; the element write follows data_valid in the same cycle,
  // and every output is held low while reset is asserted.
  always_comb begin
    write_ready  = 1'b0;
    writer_ready = 1'b0;
    write_done   = 1'b0;
    write_err    = 1'b0;
    bram_we      = 1'b0;
    bram_addr    = '0;
    bram_wdata   = '0;
    if (!rst) begin
      case (r_state)
        IDLE: write_ready = 1'b1;
        META0: begin
          bram_we    = 1'b1;
          bram_addr  = r_base;
          bram_wdata = DATA_WIDTH'({r_rows, r_cols, 16'h0000});
        end
        META1: begin
          bram_we    = 1'b1;
          bram_addr  = r_base + ADDR_WIDTH'(1);
          bram_wdata = DATA_WIDTH'({r_name[0], r_name[1], r_name[2], r_name[3]});
        end
        META2: begin
          bram_we    = 1'b1;
          bram_addr  = r_base + ADDR_WIDTH'(2);
          bram_wdata = DATA_WIDTH'({r_name[4], r_name[5], r_name[6], r_name[7]});
        end
        STREAM: begin
          writer_ready = 1'b1;
          bram_we      = data_valid;
          bram_addr    = r_base + ADDR_WIDTH'(META_WORDS) + ADDR_WIDTH'(r_idx);
          bram_wdata   = data_in;
        end
        DONE: write_done = 1'b1;
        ERR: begin
          write_done = 1'b1;
          write_err  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_writer.sv
// Self-checking bench for matrix_writer: randomized matrices against a
// slot-image model (header words + element list) and a BRAM write log.
module tb_matrix_writer;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int BS = 256;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write_request = 1'b0;
  logic          write_ready;
  logic [2:0]    matrix_id = '0;
  logic [7:0]    actual_rows = '0;
  logic [7:0]    actual_cols = '0;
  logic [7:0]    matrix_name [0:7];
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          writer_ready;
  logic          write_done;
  logic          write_err;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata;

  always #5 clk = ~clk;

  matrix_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .META_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .write_request(write_request), .write_ready(write_ready),
    .matrix_id(matrix_id), .actual_rows(actual_rows), .actual_cols(actual_cols),
    .matrix_name(matrix_name), .data_in(data_in), .data_valid(data_valid),
    .writer_ready(writer_ready), .write_done(write_done), .write_err(write_err),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t           wlog[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Reference slot image
  logic [DW-1:0] data_q[$];
  logic [7:0]    g_rows, g_cols;
  logic [63:0]   g_name;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bram_we === 1'b1) begin
      wlog.push_back('{cyc, bram_addr, bram_wdata});
      mem[bram_addr] = bram_wdata;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [DW-1:0] exp_word(int k);
    if (k == 0) return {g_rows, g_cols, 16'h0000};
    if (k == 1) return g_name[63:32];
    if (k == 2) return g_name[31:0];
    return data_q[k-3];
  endfunction

  task automatic drive_fields(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c,
                              input logic [63:0] nm);
    matrix_id   = id;
    actual_rows = r;
    actual_cols = c;
    for (int i = 0; i < 8; i++) matrix_name[i] = nm[63-8*i -: 8];
  endtask

  // Raise a request and wait for it to be accepted; returns at posedge+1 of the
  // first cycle after acceptance.
  task automatic issue(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c,
                       input logic [63:0] nm, input bit hold, output int acc);
    drive_fields(id, r, c, nm);
    write_request = 1'b1;
    acc = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (write_ready === 1'b1) begin
        acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (acc < 0) begin
      n_fail++;
      $display("FAIL issue_timeout: write_ready=%b required 1", write_ready);
    end
    @(posedge clk); #1;
    if (!hold) begin
      write_request = 1'b0;
      drive_fields(3'($urandom), 8'($urandom), 8'($urandom), {$urandom, $urandom});
    end
  endtask

  // Offer data_q elements with random valid gaps until write_done.
  task automatic pump(input int pct, output int done_cyc, output bit err, output int wr_hi);
    int ptr;
    ptr = 0;
    done_cyc = -1;
    err = 1'b0;
    wr_hi = 0;
    for (int t = 0; t < 800; t++) begin
      if (ptr < data_q.size()) begin
        data_valid = ($urandom_range(99) < pct);
        data_in    = data_q[ptr];
      end else begin
        data_valid = 1'($urandom_range(1));
        data_in    = $urandom;
      end
      @(negedge clk);
      if (writer_ready === 1'b1) wr_hi++;
      if (data_valid && writer_ready === 1'b1) ptr++;
      if (write_done === 1'b1) begin
        done_cyc = cyc;
        err = write_err;
      end
      @(posedge clk); #1;
      if (done_cyc >= 0) break;
    end
    data_valid = 1'b0;
    n_chk++;
    if (done_cyc < 0) begin
      n_fail++;
      $display("FAIL pump_timeout: write_done never seen, accepted %0d of %0d", ptr, data_q.size());
    end
  endtask

  // Full transaction against the slot-image model.
  task automatic test_write(input string tag, input logic [2:0] id, input logic [7:0] r,
                            input logic [7:0] c, input logic [63:0] nm, input int pct,
                            input bit preset);
    int acc, dn, wh, w0, nw;
    bit err, exp_err;
    logic [15:0] elem;
    logic [AW-1:0] base;
    g_rows = r; g_cols = c; g_name = nm;
    elem = 16'(r) * 16'(c);
    exp_err = (int'(elem) > BS - MW);
    base = AW'(int'(id) * BS);
    if (!preset) begin
      data_q.delete();
      if (!exp_err) for (int k = 0; k < int'(elem); k++) data_q.push_back($urandom);
    end
    w0 = wlog.size();
    issue(id, r, c, nm, 1'b0, acc);
    pump(pct, dn, err, wh);
    nw = wlog.size() - w0;
    n_chk++;
    if (err !== exp_err) begin
      n_fail++; $display("FAIL %s err: got %b required %b", tag, err, exp_err);
    end
    if (exp_err) begin
      n_chk++;
      if (nw != 0) begin n_fail++; $display("FAIL %s err_writes: got %0d required 0", tag, nw); end
      n_chk++;
      if (dn != acc + 1) begin n_fail++; $display("FAIL %s err_latency: done cyc %0d required %0d", tag, dn, acc + 1); end
      n_chk++;
      if (wh != 0) begin n_fail++; $display("FAIL %s err_writer_ready: high %0d cycles required 0", tag, wh); end
    end else begin
      n_chk++;
      if (nw != 3 + int'(elem)) begin
        n_fail++; $display("FAIL %s write_count: got %0d required %0d", tag, nw, 3 + int'(elem));
      end else begin
        for (int k = 0; k < nw; k++) begin
          n_chk++;
          if (wlog[w0+k].a !== base + AW'(k)) begin
            n_fail++; $display("FAIL %s addr[%0d]: got %h required %h", tag, k, wlog[w0+k].a, base + AW'(k));
          end
          n_chk++;
          if (wlog[w0+k].d !== exp_word(k)) begin
            n_fail++; $display("FAIL %s data[%0d]: got %h required %h", tag, k, wlog[w0+k].d, exp_word(k));
          end
          if (k < 3) begin
            n_chk++;
            if (wlog[w0+k].c != acc + 1 + k) begin
              n_fail++; $display("FAIL %s meta_cycle[%0d]: got %0d required %0d", tag, k, wlog[w0+k].c, acc + 1 + k);
            end
          end
        end
        n_chk++;
        if (dn != wlog[w0+nw-1].c + 1) begin
          n_fail++; $display("FAIL %s done_latency: got %0d required %0d", tag, dn, wlog[w0+nw-1].c + 1);
        end
      end
      if (elem == 16'd0) begin
        n_chk++;
        if (wh != 0) begin n_fail++; $display("FAIL %s writer_ready: high %0d cycles required 0", tag, wh); end
      end
    end
    @(negedge clk);
    n_chk++;
    if ({write_done, write_ready} !== 2'b01) begin
      n_fail++; $display("FAIL %s after_done: done=%b ready=%b required done=0 ready=1", tag, write_done, write_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    write_request = 1'b1;
    data_valid = 1'b1;
    drive_fields(3'd5, 8'd2, 8'd2, 64'h0123_4567_89ab_cdef);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if ({write_ready, writer_ready, write_done, write_err, bram_we, bram_addr, bram_wdata} !== '0) begin
        n_fail++; $display("FAIL reset_outputs: ready=%b wready=%b done=%b err=%b we=%b addr=%h wdata=%h required all 0",
                           write_ready, writer_ready, write_done, write_err, bram_we, bram_addr, bram_wdata);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    write_request = 1'b0;
    data_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({write_ready, bram_we, write_done} !== 3'b100) begin
      n_fail++; $display("FAIL reset_release: ready=%b we=%b done=%b required 1 0 0", write_ready, bram_we, write_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    data_q = '{32'd1, 32'd4, 32'd2, 32'd5, 32'd3, 32'd6};
    test_write("basic", 3'd0, 8'd2, 8'd3, 64'h5453_5200_0000_0000, 100, 1'b1);
    n_chk++;
    if (mem[0] !== 32'h0203_0000) begin n_fail++; $display("FAIL basic_hdr: got %h required 02030000", mem[0]); end
    n_chk++;
    if (mem[1] !== 32'h5453_5200) begin n_fail++; $display("FAIL basic_name: got %h required 54535200", mem[1]); end
    n_chk++;
    if (mem[8] !== 32'd6) begin n_fail++; $display("FAIL basic_last: got %h required 6", mem[8]); end
  endtask

  task automatic test_gaps();
    test_write("gaps", 3'd2, 8'd3, 8'd1, {$urandom, $urandom}, 50, 1'b0);
    test_write("gaps_heavy", 3'd7, 8'd4, 8'd5, {$urandom, $urandom}, 25, 1'b0);
  endtask

  task automatic test_empty();
    test_write("empty", 3'd3, 8'd0, 8'd0, {$urandom, $urandom}, 100, 1'b0);
    test_write("empty_row", 3'd1, 8'd9, 8'd0, {$urandom, $urandom}, 100, 1'b0);
  endtask

  task automatic test_capacity();
    test_write("ovf255", 3'd5, 8'd255, 8'd255, {$urandom, $urandom}, 100, 1'b0);
    test_write("cap254", 3'd6, 8'd2, 8'd127, {$urandom, $urandom}, 100, 1'b0);
    test_write("cap253", 3'd5, 8'd11, 8'd23, {$urandom, $urandom}, 80, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      test_write("random", 3'($urandom), 8'($urandom_range(15)), 8'($urandom_range(15)),
                 {$urandom, $urandom}, 30 + $urandom_range(70), 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int acc, ptr, w0;
    data_q.delete();
    for (int k = 0; k < 6; k++) data_q.push_back($urandom);
    w0 = wlog.size();
    issue(3'd1, 8'd2, 8'd3, {$urandom, $urandom}, 1'b0, acc);
    ptr = 0;
    for (int t = 0; t < 30 && ptr < 2; t++) begin
      data_valid = 1'b1;
      data_in = data_q[ptr];
      @(negedge clk);
      if (writer_ready === 1'b1) ptr++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({write_ready, writer_ready, write_done, write_err, bram_we, bram_addr, bram_wdata} !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: done=%b we=%b addr=%h required all 0", write_done, bram_we, bram_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    data_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({write_ready, write_done, bram_we} !== 3'b100) begin
      n_fail++; $display("FAIL midrst_idle: ready=%b done=%b we=%b required 1 0 0", write_ready, write_done, bram_we);
    end
    n_chk++;
    if (wlog.size() - w0 != 5) begin
      n_fail++; $display("FAIL midrst_writes: got %0d required 5", wlog.size() - w0);
    end
    @(posedge clk); #1;
    test_write("after_rst", 3'd6, 8'd1, 8'd1, {$urandom, $urandom}, 100, 1'b0);
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, dn1, dn2, wh, w0;
    bit e1, e2;
    logic [DW-1:0] d2[$];
    logic [63:0] nm2;
    nm2 = {$urandom, $urandom};
    data_q.delete();
    for (int k = 0; k < 4; k++) data_q.push_back($urandom);
    for (int k = 0; k < 6; k++) d2.push_back($urandom);
    w0 = wlog.size();
    issue(3'd1, 8'd2, 8'd2, {$urandom, $urandom}, 1'b1, acc1);
    drive_fields(3'd4, 8'd3, 8'd2, nm2);
    pump(100, dn1, e1, wh);
    n_chk++;
    if (e1 !== 1'b0) begin n_fail++; $display("FAIL b2b_err1: got %b required 0", e1); end
    data_q = d2;
    issue(3'd4, 8'd3, 8'd2, nm2, 1'b0, acc2);
    n_chk++;
    if (acc2 != dn1 + 1) begin n_fail++; $display("FAIL b2b_accept: cyc %0d required %0d", acc2, dn1 + 1); end
    pump(70, dn2, e2, wh);
    n_chk++;
    if (e2 !== 1'b0) begin n_fail++; $display("FAIL b2b_err2: got %b required 0", e2); end
    n_chk++;
    if (wlog.size() - w0 != 16) begin n_fail++; $display("FAIL b2b_writes: got %0d required 16", wlog.size() - w0); end
    g_rows = 8'd3; g_cols = 8'd2; g_name = nm2;
    for (int k = 0; k < 9; k++) begin
      n_chk++;
      if (mem[4*BS+k] !== exp_word(k)) begin
        n_fail++; $display("FAIL b2b_slot4[%0d]: got %h required %h", k, mem[4*BS+k], exp_word(k));
      end
    end
    @(negedge clk);
    n_chk++;
    if (write_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: ready=%b required 1", write_ready); end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) matrix_name[i] = '0;
    #1;
    test_reset();
    test_basic();
    test_gaps();
    test_empty();
    test_capacity();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_writer.md
MATRIX_WRITER -- requirements
Module: matrix_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default MATRIX_DATA_WIDTH (32), element and BRAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default MATRIX_ADDR_WIDTH, BRAM address width.
REQ-003 SHALL have parameter BLOCK_SIZE, default MATRIX_BLOCK_SIZE, words per matrix slot.
REQ-004 SHALL have parameter META_WORDS, default MATRIX_METADATA_WORDS (3), header words per slot.
REQ-005 SHALL have the single clock and the reset as follows: clk in 1, sole clock (rising edge); rst in 1, synchronous active-high reset.
REQ-006 SHALL have port write_request, in, 1 bit: requester asks to store a matrix.
REQ-007 SHALL have port write_ready, out, 1 bit: writer idle and able to accept a request.
REQ-008 SHALL have port matrix_id, in, 3 bits: destination slot.
REQ-009 SHALL have ports actual_rows and actual_cols, in, 8 bits each: matrix shape.
REQ-010 SHALL have port matrix_name, in, 8x8 bits [0:7]: name bytes.
REQ-011 SHALL have ports data_in (in, DATA_WIDTH) and data_valid (in, 1): element stream, row-major.
REQ-012 SHALL have port writer_ready, out, 1 bit: element beat is accepted in this cycle when data_valid is high.
REQ-013 SHALL have port write_done, out, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port write_err, out, 1 bit: qualifies write_done, capacity rejection.
REQ-015 SHALL have BRAM write ports bram_we (out, 1), bram_addr (out, ADDR_WIDTH) and bram_wdata (out, DATA_WIDTH).

Function
REQ-016 SHALL implement the FSM states IDLE, META0, META1, META2, STREAM, DONE, ERR.
REQ-017 write_ready SHALL be 1 only in IDLE with rst low; writer_ready SHALL be 1 only in STREAM.
REQ-018 In IDLE, when write_request&write_ready, SHALL capture id, rows, cols and name.
REQ-019 At the same capture, SHALL compute base=matrix_id*BLOCK_SIZE, truncated to ADDR_WIDTH.
REQ-020 At the same capture, SHALL compute elem=rows*cols as a 16-bit product.
REQ-021 At the same capture, SHALL go to ERR if elem > BLOCK_SIZE-META_WORDS, else to META0.
REQ-022 In META0, SHALL drive bram_we=1, addr=base+0, wdata={rows,cols,16'h0}.
REQ-023 In META1, SHALL drive bram_we=1, addr=base+1, wdata={name[0],name[1],name[2],name[3]}.
REQ-024 In META2, SHALL drive bram_we=1, addr=base+2, wdata={name[4],name[5],name[6],name[7]}.
REQ-025 After META2, SHALL go to STREAM if elem!=0, else to DONE.
REQ-026 In STREAM, SHALL drive bram_we=data_valid, addr=base+META_WORDS+idx, wdata=data_in; idx SHALL increment per accepted beat.
REQ-027 In STREAM, SHALL go to DONE on the beat where idx+1==elem.
REQ-028 A data_valid gap in STREAM SHALL stall with no write and no idx change.
REQ-029 DONE SHALL assert write_done=1, write_err=0 for exactly one cycle, then go to IDLE.
REQ-030 ERR SHALL assert write_done=1, write_err=1 for one cycle with no BRAM write, then go to IDLE.
REQ-031 bram_we SHALL be 0 in IDLE, DONE and ERR; data_valid outside STREAM SHALL be ignored.
REQ-032 write_request outside IDLE SHALL be ignored; captured fields SHALL be stable for the whole transaction regardless of input changes.
REQ-033 Latency SHALL be: request accept to first metadata write 1 cycle; the 3 metadata writes in consecutive cycles; write_done 1 cycle after the last element write.
REQ-034 Back-to-back: a new request SHALL be accepted on the cycle after DONE (IDLE re-entered).

Reset
REQ-035 rst high at a clock edge SHALL force IDLE, idx=0 and captured registers to 0.
REQ-036 While rst is high, write_ready, writer_ready, write_done, write_err and bram_we SHALL all be 0; bram_addr and bram_wdata SHALL be 0.
REQ-037 Reset mid-transaction SHALL abort with no write_done; words already written SHALL stay; the next request SHALL be accepted normally.

Verification
REQ-038 id=0, 2x3, name "TSR", stream 1,4,2,5,3,6 contiguously -> words base0..8 = {8'd2,8'd3,16'h0}, 32'h54535200, 0, 1,4,2,5,3,6; one write_done, write_err=0.
REQ-039 id=2, 3x1, data_valid toggling 1,0,1,0,1 -> 3 element writes only on valid cycles; write_done 1 cycle after the 3rd; no writes at base+6.
REQ-040 id=3, 0x0 -> exactly 3 metadata writes, then write_done; writer_ready never high.
REQ-041 rows=cols=255 with elem > BLOCK_SIZE-3 -> no bram_we; write_done=write_err=1 for one cycle, then write_ready=1.
REQ-042 rst pulsed after 2 of 6 elements -> no write_done, IDLE next cycle; a subsequent 1x1 request completes correctly.
REQ-043 Two requests back-to-back (ids 1, 4) with write_request held high -> second accepted the cycle after the first write_done; slot 4 contents correct.
